// File: rtl/receptor_16_uc.sv
// receptor_16_uc: control unit that assembles two received UART bytes into one 16-bit word (optional parity check via RECEPTOR_16_PARITY_CHECK_EN)
module receptor_16_uc #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter bit HIGH_FIRST     = 1'b1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_iniciar,
  input  logic       i_fim_receber,
  input  logic       i_parity_ok,
  output logic       o_load_data_high,
  output logic       o_load_data_low,
  output logic       o_pronto,
  output logic       o_erro,
  output logic       o_timeout,
  output logic [3:0] o_db_estado
);
  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    ESPERA_1  = 4'd1,
    CARREGA_1 = 4'd2,
    ESPERA_2  = 4'd3,
    CARREGA_2 = 4'd4,
    PRONTO    = 4'd5,
    ERRO      = 4'd15
  } state_t;
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
`ifdef RECEPTOR_16_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_to;
  logic            w_bad;
  logic            w_to_hit;
  assign w_bad    = PAR_EN && !i_parity_ok;
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  // state register, inter-byte counter and timeout-cause flag
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= INICIAL;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == CARREGA_1) ? '0 :
                 (r_state == ESPERA_2 && r_cnt != TO_MAX) ? r_cnt + 1'b1 : r_cnt;
      r_to    <= (r_state == ESPERA_2 && !i_fim_receber && w_to_hit) ? 1'b1 :
                 (r_state == ERRO && !i_iniciar) ? r_to : 1'b0;
    end
  end
  // next state; a byte arriving on the last allowed cycle beats the timeout
  always_comb begin
    w_next = INICIAL;
    case (r_state)
      INICIAL:   w_next = i_iniciar ? ESPERA_1 : INICIAL;
      ESPERA_1:  w_next = !i_fim_receber ? ESPERA_1 : w_bad ? ERRO : CARREGA_1;
      CARREGA_1: w_next = ESPERA_2;
      ESPERA_2:  w_next = i_fim_receber ? (w_bad ? ERRO : CARREGA_2) : w_to_hit ? ERRO : ESPERA_2;
      CARREGA_2: w_next = PRONTO;
      PRONTO:    w_next = INICIAL;
      ERRO:      w_next = i_iniciar ? ESPERA_1 : ERRO;
      default:   w_next = INICIAL;
    endcase
  end
  assign o_load_data_high = HIGH_FIRST ? (r_state == CARREGA_1) : (r_state == CARREGA_2);
  assign o_load_data_low  = HIGH_FIRST ? (r_state == CARREGA_2) : (r_state == CARREGA_1);
  assign o_pronto         = (r_state == PRONTO);
  assign o_erro           = (r_state == ERRO);
  assign o_timeout        = (r_state == ERRO) && r_to;
  assign o_db_estado      = r_state;
endmodule

// File: tb/tb_receptor_16_uc.sv
// tb_receptor_16_uc: scoreboard bench for receptor_16_uc, both byte orders side by side
module tb_receptor_16_uc;
  logic clk = 1'b0;
  logic rst_n, ini, fim, par;
  logic [7:0] byte_in;
  logic lh_a, ll_a, pr_a, er_a, to_a, lh_b, ll_b, pr_b, er_b, to_b;
  logic [3:0] st_a, st_b;
  logic [15:0] reg_a = '0, reg_b = '0;
  logic [15:0] q_a[$], q_b[$];
  int n_chk = 0, n_err = 0, n_pr_a = 0, n_pr_b = 0;
  always #5 clk = ~clk;
  receptor_16_uc #(.TIMEOUT_CYCLES(16), .HIGH_FIRST(1'b1)) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_iniciar(ini), .i_fim_receber(fim), .i_parity_ok(par),
    .o_load_data_high(lh_a), .o_load_data_low(ll_a), .o_pronto(pr_a), .o_erro(er_a),
    .o_timeout(to_a), .o_db_estado(st_a));
  receptor_16_uc #(.TIMEOUT_CYCLES(16), .HIGH_FIRST(1'b0)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_iniciar(ini), .i_fim_receber(fim), .i_parity_ok(par),
    .o_load_data_high(lh_b), .o_load_data_low(ll_b), .o_pronto(pr_b), .o_erro(er_b),
    .o_timeout(to_b), .o_db_estado(st_b));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic p);
    byte_in = b;
    par = p;
    fim = 1'b1;
    tick();
    fim = 1'b0;
  endtask
  task automatic start_word();
    ini = 1'b1;
    tick();
    ini = 1'b0;
  endtask
  // receive datapath register loaded by the strobes
  always @(posedge clk) begin
    if (lh_a) reg_a[15:8] <= byte_in;
    if (ll_a) reg_a[7:0]  <= byte_in;
    if (lh_b) reg_b[15:8] <= byte_in;
    if (ll_b) reg_b[7:0]  <= byte_in;
  end
  // scoreboard: each pronto pulse pops the expected word
  always @(negedge clk) begin
    if (lh_a && ll_a) chk("both_strobes_a", 16'(lh_a & ll_a), 16'h0);
    if (lh_b && ll_b) chk("both_strobes_b", 16'(lh_b & ll_b), 16'h0);
    if (pr_a) begin
      n_pr_a++;
      if (q_a.size() == 0) chk("unexpected_pronto_a", 16'h1, 16'h0);
      else chk("word_a", reg_a, q_a.pop_front());
    end
    if (pr_b) begin
      n_pr_b++;
      if (q_b.size() == 0) chk("unexpected_pronto_b", 16'h1, 16'h0);
      else chk("word_b", reg_b, q_b.pop_front());
    end
  end
  initial begin
    rst_n = 1'b0; ini = 1'b0; fim = 1'b0; par = 1'b1; byte_in = 8'h00;
    tick(); tick();
    chk("reset_state", {12'h0, st_a}, 16'h0);
    chk("reset_outs", {11'h0, lh_a, ll_a, pr_a, er_a, to_a}, 16'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_state", {12'h0, st_a}, 16'h0);
    // normal word A5,3C
    start_word();
    chk("espera1", {12'h0, st_a}, 16'h1);
    q_a.push_back(16'hA53C);
    q_b.push_back(16'h3CA5);
    send_byte(8'hA5, 1'b1);
    chk("carrega1_state", {12'h0, st_a}, 16'h2);
    chk("carrega1_strobes_a", {14'h0, lh_a, ll_a}, 16'h2);
    chk("carrega1_strobes_b", {14'h0, lh_b, ll_b}, 16'h1);
    ini = 1'b1;
    tick(); tick(); tick();
    ini = 1'b0;
    chk("iniciar_ignored", {12'h0, st_a}, 16'h3);
    send_byte(8'h3C, 1'b1);
    chk("carrega2_strobes_a", {13'h0, lh_a, ll_a, pr_a}, 16'h2);
    chk("carrega2_strobes_b", {13'h0, lh_b, ll_b, pr_b}, 16'h4);
    tick();
    chk("pronto_a", {15'h0, pr_a}, 16'h1);
    chk("pronto_b", {15'h0, pr_b}, 16'h1);
    tick();
    chk("back_idle", {11'h0, st_a, pr_a}, 16'h0);
    // timeout: only the first byte arrives
    start_word();
    send_byte(8'h11, 1'b1);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("espera2_last_cycle", {11'h0, st_a, er_a}, {11'h0, 4'h3, 1'b0});
    tick();
    chk("timeout_state", {12'h0, st_a}, 16'hF);
    chk("timeout_flags_a", {14'h0, er_a, to_a}, 16'h3);
    chk("timeout_flags_b", {14'h0, er_b, to_b}, 16'h3);
    tick(); tick();
    chk("erro_held", {14'h0, er_a, to_a}, 16'h3);
    // recovery, second byte on the last allowed cycle
    start_word();
    chk("recover", {10'h0, st_a, er_a, to_a}, {10'h0, 4'h1, 2'b00});
    send_byte(8'h5A, 1'b1);
    tick();
    for (int i = 0; i < 15; i++) tick();
    q_a.push_back(16'h5AC3);
    q_b.push_back(16'hC35A);
    send_byte(8'hC3, 1'b1);
    chk("fim_beats_timeout", {11'h0, st_a, er_a}, {11'h0, 4'h4, 1'b0});
    tick();
    chk("recover_pronto", {15'h0, pr_a}, 16'h1);
    tick();
    // bad parity on the second byte
    start_word();
    send_byte(8'h12, 1'b1);
    tick(); tick();
`ifdef RECEPTOR_16_PARITY_CHECK_EN
    send_byte(8'h34, 1'b0);
    chk("parity_err", {10'h0, st_a, er_a, to_a}, {10'h0, 4'hF, 2'b10});
    chk("parity_no_strobe", {14'h0, lh_a, ll_a}, 16'h0);
    tick();
    chk("parity_no_pronto", {15'h0, pr_a}, 16'h0);
    start_word();
`else
    q_a.push_back(16'h1234);
    q_b.push_back(16'h3412);
    send_byte(8'h34, 1'b0);
    chk("parity_ignored", {12'h0, st_a}, 16'h4);
    tick();
    chk("parity_ignored_pronto", {15'h0, pr_a}, 16'h1);
    tick();
    start_word();
`endif
    // asynchronous reset in the middle of ESPERA_2
    send_byte(8'h77, 1'b1);
    tick(); tick();
    chk("pre_reset", {12'h0, st_a}, 16'h3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", {8'h0, st_a, st_b}, 16'h0);
    chk("async_reset_outs", {6'h0, lh_a, ll_a, pr_a, er_a, to_a, lh_b, ll_b, pr_b, er_b, to_b}, 16'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("after_reset_idle", {12'h0, st_a}, 16'h0);
    chk("queue_a_empty", 16'(q_a.size()), 16'h0);
    chk("queue_b_empty", 16'(q_b.size()), 16'h0);
`ifdef RECEPTOR_16_PARITY_CHECK_EN
    chk("pronto_count", 16'(n_pr_a + n_pr_b), 16'd4);
`else
    chk("pronto_count", 16'(n_pr_a + n_pr_b), 16'd6);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
